spi_boot_loader: RTL and testbench
==================================

# spi_boot_loader

SPI slave that receives the ARM boot image stream and turns it into byte writes into external SRAM. It sits between the ARM boot pins (`arm_ss`, `arm_sclk`, `arm_mosi`) and the SRAM write arbiter inside `Microcomputer`. It decodes a 6-byte address header followed by image data and emits one write request per data byte. While the transfer is in progress it asserts `busy`, which holds the Z80 in reset.

## Interface
- `ADDR_W`, 18: SRAM address width; header addresses are truncated to this width.
- `HDR_BYTES`, 6: header length in bytes (3 start address, 3 end address).
- `clk`  in  1: system clock (100 MHz); the only clock in the block.
- `reset`  in  1: synchronous, active-high reset.
- `arm_ss`  in  1: SPI slave select, active low, asynchronous to `clk`.
- `arm_sclk`  in  1: SPI clock, asynchronous, up to 20 MHz.
- `arm_mosi`  in  1: SPI data, MSB first, asynchronous.
- `wr_valid`  out  1: a write request is pending.
- `wr_ready`  in  1: the arbiter accepts the write this cycle.
- `wr_addr`  out  ADDR_W: SRAM address of the write.
- `wr_data`  out  8: SRAM data of the write.
- `busy`  out  1: a boot transfer is active (CPU must be held in reset).
- `done`  out  1: one-cycle pulse when the last image byte is accepted.
- `overrun`  out  1: sticky; a byte was lost. Cleared at the next `arm_ss` fall or on reset.

## Operation
- Input conditioning: each SPI pin passes through a 2-FF synchronizer plus one history FF. An sclk rising edge is detected as `sync==1 && hist==0`. `arm_mosi` is sampled from its synchronized copy in the same cycle the edge is detected.
- SPI mode: MOSI changes on the SCLK fall and is sampled on the SCLK rise, MSB first. A bit counter (3 bit) plus a shift register assemble each byte. The bit counter resets on every `arm_ss` fall.
- States:
  - IDLE: waits for the synchronized `arm_ss` fall, then goes to HEADER. `hdr_cnt`=0, `overrun` cleared, `busy`=1.
  - HEADER: each complete byte is stored little-endian. Bytes 0-2 form `start[23:0]` and bytes 3-5 form `end[23:0]`. After byte 5: if `end` < `start` (compared on 24 bits), go to DONE with no writes; otherwise set `addr`=`start[ADDR_W-1:0]` and go to DATA.
  - DATA: each complete byte is loaded into the holding register with `wr_valid`=1 and `wr_addr`=`addr`.
    - On `wr_valid && wr_ready`: the request drops.
    - If the accepted byte's 24-bit index equals `end`: pulse `done` and go to DONE. Otherwise `addr` increments, wrapping modulo 2^ADDR_W.
    - If a new byte completes while `wr_valid` is still 1: the new byte is dropped, `overrun` is set, and the address does not advance.
  - DONE: further SPI bytes are ignored and `busy` stays 1. An `arm_ss` rise returns to IDLE with `busy`=0.
- `arm_ss` rise in HEADER or DATA aborts the transfer:
  - any partial byte is discarded;
  - a pending `wr_valid` is still held until accepted, then dropped;
  - state returns to IDLE, `busy`=0 and no `done` pulse is produced.
- Reset in any state: state goes to IDLE and all counters clear. The pending write is discarded.

## Timing
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `overrun`=0.
- Pin-to-detect latency is 3 clk.
- `wr_valid` rises 1 clk after the 8th sclk edge is detected.
- `wr_addr` and `wr_data` are stable while `wr_valid`=1.
- `done` asserts in the cycle after the final handshake and lasts exactly 1 clk.
- `busy` rises 3 clk after the `arm_ss` pin falls and falls 3 clk after the `arm_ss` pin rises. When a write is pending at the rise, `busy` falls after that write is accepted.
- Minimum SCLK half-period is 25 ns (≥2 clk). Byte spacing at 20 MHz is 40 clk, so `wr_ready` latency below 40 clk never causes an overrun.

## Structure
- Shared package `boot_pkg`:
  - state enum (IDLE, HEADER, DATA, DONE);
  - `HDR_BYTES`;
  - the default `ADDR_W`.
- Sub-module `spi_sync_edge`: the 2-FF synchronizer plus edge detect. It is instantiated three times (for ss, sclk and mosi); rise/fall outputs are used for ss and sclk.
- Top level: FSM, header registers, address counter, holding register.

## Test plan
- Header start 0x000000, end 0x000003, data 11 22 33 44, `wr_ready`=1 → writes 0→11, 1→22, 2→33, 3→44; one `done` pulse; `busy` falls after ss rises.
- Start 0x000010, end 0x00000F → no writes, no `done`; `busy` stays 1 until ss rises.
- Start 0x000000, end 0x000001, data AA BB CC DD → only addresses 0 and 1 are written; CC and DD are ignored.
- `wr_ready` held low for 100 clk during the data phase at 20 MHz → the first byte is held, `overrun`=1, and the next write reuses the address of the dropped byte.
- ss rise after 4 bits of data byte 2 → 2 writes, no `done`, `busy`=0. A new transfer then decodes its header correctly.
- Reset asserted during HEADER → all outputs return to reset values; the next full transfer behaves as in the first scenario.

Source files
------------

// File: rtl/spi_boot_loader_pkg.sv
// Shared types and constants for the SPI boot loader: FSM states, header length
// and the default SRAM address width.
`timescale 1ns/1ps
package boot_pkg;
  localparam int HDR_BYTES      = 6;
  localparam int ADDR_W_DEFAULT = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/spi_boot_loader_if.sv
// SRAM write request channel towards the arbiter.
// valid/ready: wr_valid stays high with wr_addr/wr_data stable until a cycle in
// which wr_ready is also high; that cycle is the transfer, and the request drops after it.
`timescale 1ns/1ps
interface spi_boot_loader_if #(
  parameter int ADDR_W = boot_pkg::ADDR_W_DEFAULT
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/spi_boot_loader_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a history flop that yields
// single-cycle rise/fall strobes in the clk domain.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic meta_q, sync_q, hist_q;

  // Reset value matches the pin's idle level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~hist_q;
  assign fall = ~sync_q & hist_q;
endmodule

// File: rtl/spi_boot_loader.sv
// SPI slave that decodes a 6-byte start/end header and turns the following image
// bytes into SRAM write requests, holding the CPU off via busy while it runs.
`timescale 1ns/1ps
module spi_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm_ss,
  input  logic               arm_sclk,
  input  logic               arm_mosi,
  spi_boot_loader_if.master  wr,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output state_t             dbg_state
);
  localparam logic [2:0] LAST_HDR = 3'(HDR_BYTES - 1);

  logic ss_rise, ss_fall, sclk_rise, mosi_s;
  logic ss_sync_unused, sclk_sync_unused, sclk_fall_unused;
  logic mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .reset(reset), .din(arm_ss),
    .sync(ss_sync_unused), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .din(arm_sclk),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall_unused));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(arm_mosi),
    .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [2:0]        hdr_cnt_q, hdr_cnt_d;
  logic [23:0]       start_q, start_d, end_q, end_d, idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;
  logic              busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;

  logic       shifting, byte_done, accept;
  logic [7:0] byte_val;

  assign shifting  = (state_q == ST_HEADER) || (state_q == ST_DATA);
  assign byte_done = shifting && sclk_rise && (bit_cnt_q == 3'd7);
  assign byte_val  = {shift_q, mosi_s};
  assign accept    = wr_valid_q && wr.wr_ready;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hdr_cnt_d  = hdr_cnt_q;
    start_d    = start_q;
    end_d      = end_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wr_valid_d = wr_valid_q && !wr.wr_ready;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;

    if (ss_fall) begin
      bit_cnt_d = 3'd0;
      overrun_d = 1'b0;
    end else if (shifting && sclk_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {shift_q[5:0], mosi_s};
    end

    case (state_q)
      ST_IDLE: begin
        // An aborted transfer's pending write keeps busy up until it is taken.
        busy_d = wr_valid_d;
        if (ss_fall) begin
          state_d   = ST_HEADER;
          hdr_cnt_d = 3'd0;
          busy_d    = 1'b1;
        end
      end
      ST_HEADER: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          busy_d  = wr_valid_d;
        end else if (byte_done) begin
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q < 3'd3) start_d = {byte_val, start_q[23:8]};
          else                  end_d   = {byte_val, end_q[23:8]};
          if (hdr_cnt_q == LAST_HDR) begin
            if (end_d < start_q) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = start_q[ADDR_W-1:0];
              idx_d   = start_q;
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          busy_d  = wr_valid_d;
        end else begin
          if (accept) begin
            if (idx_q == end_q) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              idx_d  = idx_q + 24'd1;
              addr_d = addr_q + ADDR_W'(1);
            end
          end
          // A byte landing while the holding register is still full is lost.
          if (byte_done) begin
            if (wr_valid_q) begin
              overrun_d = 1'b1;
            end else begin
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = byte_val;
            end
          end
        end
      end
      ST_DONE: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      hdr_cnt_q  <= '0;
      start_q    <= '0;
      end_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hdr_cnt_q  <= hdr_cnt_d;
      start_q    <= start_d;
      end_q      <= end_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: SPI byte driver, expected-write queue with a
// negedge monitor, and directed transfer scenarios.
`timescale 1ns/1ps
module tb_spi_boot_loader;
  import boot_pkg::*;
  localparam int AW = 18;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset, arm_ss, arm_sclk, arm_mosi;
  logic   busy, done, overrun;
  state_t dbg_state;

  always #5 clk = ~clk;

  spi_boot_loader_if #(.ADDR_W(AW)) wr ();

  spi_boot_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .arm_ss(arm_ss), .arm_sclk(arm_sclk),
    .arm_mosi(arm_mosi), .wr(wr), .busy(busy), .done(done),
    .overrun(overrun), .dbg_state(dbg_state));

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int half_ns      = 30;

  logic [AW+7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          prev_valid = 1'b0, prev_acc = 1'b0, prev_done = 1'b0;
  logic [AW+7:0] prev_word = '0;
  logic [AW+7:0] got_word, exp_word;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      prev_done  = 1'b0;
    end else begin
      got_word = {wr.wr_addr, wr.wr_data};
      if (prev_valid && !prev_acc && wr.wr_valid)
        check("hold_stable", 32'(got_word), 32'(prev_word));
      if (wr.wr_valid && wr.wr_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_write: actual addr %0h data %0h required none",
                   wr.wr_addr, wr.wr_data);
        end else begin
          exp_word = exp_q.pop_front();
          check("write", 32'(got_word), 32'(exp_word));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_width", 32'(prev_done), 32'(0));
      end
      prev_valid = wr.wr_valid;
      prev_acc   = wr.wr_valid && wr.wr_ready;
      prev_word  = got_word;
      prev_done  = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      arm_sclk = 1'b0;
      arm_mosi = b[i];
      #(half_ns);
      arm_sclk = 1'b1;
      #(half_ns);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic header(input logic [23:0] s, input logic [23:0] e);
    spi_byte(s[7:0]);  spi_byte(s[15:8]); spi_byte(s[23:16]);
    spi_byte(e[7:0]);  spi_byte(e[15:8]); spi_byte(e[23:16]);
  endtask

  task automatic start_xfer();
    arm_sclk = 1'b0;
    arm_ss   = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic end_xfer();
    arm_sclk = 1'b0;
    #(half_ns);
    arm_ss = 1'b1;
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_busy(input string name, input logic val);
    int n = 0;
    while (busy !== val && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'(val));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_valid"}, 32'(wr.wr_valid), 32'(0));
    check({tag, "_wr_addr"},  32'(wr.wr_addr),  32'(0));
    check({tag, "_wr_data"},  32'(wr.wr_data),  32'(0));
    check({tag, "_busy"},     32'(busy),        32'(0));
    check({tag, "_done"},     32'(done),        32'(0));
    check({tag, "_overrun"},  32'(overrun),     32'(0));
    check({tag, "_state"},    32'(dbg_state),   32'(ST_IDLE));
  endtask

  task automatic run_basic(input string tag);
    int d0;
    d0 = done_cnt;
    wr.wr_ready = 1'b1;
    push(18'h0, 8'h11); push(18'h1, 8'h22); push(18'h2, 8'h33); push(18'h3, 8'h44);
    start_xfer();
    check({tag, "_busy_up"}, 32'(busy), 32'(1));
    header(24'h000000, 24'h000003);
    spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_byte(8'h44);
    settle();
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(d0 + 1));
    check({tag, "_q_empty"},  32'(exp_q.size()), 32'(0));
    check({tag, "_busy_hold"}, 32'(busy), 32'(1));
    check({tag, "_state_done"}, 32'(dbg_state), 32'(ST_DONE));
    end_xfer();
    wait_busy({tag, "_busy_fall"}, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    reset = 1'b1; arm_ss = 1'b1; arm_sclk = 1'b0; arm_mosi = 1'b0;
    wr.wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Four-byte image at address 0.
    run_basic("s1");

    // end < start: header only, no writes.
    d0 = done_cnt;
    start_xfer();
    header(24'h000010, 24'h00000F);
    spi_byte(8'h55);
    settle();
    check("s2_state", 32'(dbg_state), 32'(ST_DONE));
    check("s2_busy", 32'(busy), 32'(1));
    check("s2_done_cnt", 32'(done_cnt), 32'(d0));
    end_xfer();
    wait_busy("s2_busy_fall", 1'b0);

    // Bytes past the end address are ignored.
    d0 = done_cnt;
    push(18'h0, 8'hAA); push(18'h1, 8'hBB);
    start_xfer();
    header(24'h000000, 24'h000001);
    spi_byte(8'hAA); spi_byte(8'hBB); spi_byte(8'hCC); spi_byte(8'hDD);
    settle();
    check("s3_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    check("s3_q_empty", 32'(exp_q.size()), 32'(0));
    end_xfer();
    wait_busy("s3_busy_fall", 1'b0);

    // Stalled arbiter at 20 MHz SCLK: D1/D2 lost, D3 reuses D1's address.
    d0 = done_cnt;
    half_ns = 25;
    wr.wr_ready = 1'b0;
    push(18'h100, 8'hD0);
    push(18'h101, 8'hD3); push(18'h102, 8'hD4); push(18'h103, 8'hD5);
    push(18'h104, 8'hD6); push(18'h105, 8'hD7);
    start_xfer();
    header(24'h000100, 24'h000105);
    spi_byte(8'hD0);
    fork
      begin
        repeat (100) @(posedge clk);
        wr.wr_ready = 1'b1;
      end
      begin
        spi_byte(8'hD1);
        spi_byte(8'hD2);
      end
    join
    @(negedge clk);
    check("s4_overrun", 32'(overrun), 32'(1));
    spi_byte(8'hD3); spi_byte(8'hD4); spi_byte(8'hD5);
    spi_byte(8'hD6); spi_byte(8'hD7);
    settle();
    check("s4_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    check("s4_q_empty", 32'(exp_q.size()), 32'(0));
    check("s4_overrun_sticky", 32'(overrun), 32'(1));
    end_xfer();
    wait_busy("s4_busy_fall", 1'b0);
    half_ns = 30;

    // Abort mid-byte, then a fresh transfer whose address wraps.
    d0 = done_cnt;
    push(18'h20, 8'h5A); push(18'h21, 8'h6B);
    start_xfer();
    check("s5_overrun_clr", 32'(overrun), 32'(0));
    header(24'h000020, 24'h000030);
    spi_byte(8'h5A); spi_byte(8'h6B);
    spi_bits(8'hC3, 4);
    end_xfer();
    wait_busy("s5_busy_fall", 1'b0);
    settle();
    check("s5_state", 32'(dbg_state), 32'(ST_IDLE));
    check("s5_no_done", 32'(done_cnt), 32'(d0));
    check("s5_q_empty", 32'(exp_q.size()), 32'(0));
    push(18'h3FFFF, 8'h77); push(18'h00000, 8'h88);
    start_xfer();
    header(24'h03FFFF, 24'h040000);
    spi_byte(8'h77); spi_byte(8'h88);
    settle();
    check("s5b_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    check("s5b_q_empty", 32'(exp_q.size()), 32'(0));
    end_xfer();
    wait_busy("s5b_busy_fall", 1'b0);

    // Reset while the header is half received.
    start_xfer();
    spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00);
    @(negedge clk);
    check("s6_state_hdr", 32'(dbg_state), 32'(ST_HEADER));
    @(posedge clk);
    reset  = 1'b1;
    arm_ss = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("s6");
    @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    run_basic("s6b");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish within 1 ms");
    $fatal(1, "timeout");
  end
endmodule
